// File: rtl/mac_pkg.sv
// Shared constants and encodings for the MAC operand sequencer.
package mac_pkg;
  localparam int MAT_N = 3;
  localparam int OP_W  = 4;
  localparam int ACC_W = 10;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_ACC,
    ST_WAIT,
    ST_CAP,
    ST_DONE
  } state_t;
endpackage

// File: rtl/mac_operand_sequencer_if.sv
// Host write/start/result signals plus the MAC operand/result bus.
interface mac_operand_sequencer_if;
  import mac_pkg::*;

  logic             wr_en;
  logic             wr_sel;
  logic [3:0]       wr_addr;
  logic [OP_W-1:0]  wr_data;
  logic             start;
  logic             busy;
  logic             done;
  logic [OP_W-1:0]  mac_w;
  logic [OP_W-1:0]  mac_x;
  logic             mac_load;
  logic             mac_clear;
  logic [ACC_W-1:0] mac_o;
  logic             res_valid;
  logic [3:0]       res_addr;
  logic [ACC_W-1:0] res_data;

  modport seq (
    input  wr_en, wr_sel, wr_addr, wr_data, start, mac_o,
    output busy, done, mac_w, mac_x, mac_load, mac_clear,
           res_valid, res_addr, res_data
  );

  modport host (
    output wr_en, wr_sel, wr_addr, wr_data, start, mac_o,
    input  busy, done, mac_w, mac_x, mac_load, mac_clear,
           res_valid, res_addr, res_data
  );
endinterface

// File: rtl/mac_operand_sequencer_operand_bank.sv
// 3x3 row-major operand register file: one write port, one combinational read port.
module operand_bank
  import mac_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [3:0]      waddr,
  input  logic [OP_W-1:0] wdata,
  input  logic [3:0]      raddr,
  output logic [OP_W-1:0] rdata
);
  localparam logic [3:0] DEPTH = 4'(MAT_N * MAT_N);

  logic [MAT_N*MAT_N-1:0][OP_W-1:0] mem;

  // Out-of-range addresses never touch storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      mem <= '0;
    else if (we && waddr < DEPTH) mem[waddr] <= wdata;
  end

  assign rdata = (raddr < DEPTH) ? mem[raddr] : '0;
endmodule

// File: rtl/mac_operand_sequencer.sv
// Streams A[i][k]/B[k][j] pairs into an external MAC and captures the 9 sums of C = A x B.
module mac_operand_sequencer
  import mac_pkg::*;
#(
  parameter int N       = MAT_N,
  parameter int MAC_LAT = 1
) (
  input logic                  clk,
  input logic                  rst,
  mac_operand_sequencer_if.seq bus
);
  localparam logic [1:0] LAST      = 2'(N - 1);
  localparam logic [3:0] ROW       = 4'(N);
  localparam logic [7:0] WAIT_LAST = 8'(MAC_LAT - 1);

  state_t               state, state_n;
  logic [1:0]           i, j, k, i_n, j_n, k_n;
  logic [7:0]           wcnt, wcnt_n;
  logic [1:0]           we;
  logic [1:0][3:0]      raddr;
  logic [1:0][OP_W-1:0] rdata;

  assign we[0] = bus.wr_en && (state == ST_IDLE) && (bus.wr_sel == SEL_A);
  assign we[1] = bus.wr_en && (state == ST_IDLE) && (bus.wr_sel == SEL_B);

  // Read with the next k so the registered operands line up with the ACC cycle.
  assign raddr[0] = {2'b00, i}   * ROW + {2'b00, k_n};
  assign raddr[1] = {2'b00, k_n} * ROW + {2'b00, j};

  for (genvar g = 0; g < 2; g++) begin : g_bank
    operand_bank u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (we[g]),
      .waddr (bus.wr_addr),
      .wdata (bus.wr_data),
      .raddr (raddr[g]),
      .rdata (rdata[g])
    );
  end

  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    k_n     = k;
    wcnt_n  = wcnt;
    case (state)
      ST_IDLE: if (bus.start) begin
        state_n = ST_CLR;
        i_n     = '0;
        j_n     = '0;
      end
      ST_CLR: begin
        state_n = ST_ACC;
        k_n     = '0;
      end
      ST_ACC: if (k == LAST) begin
        state_n = ST_WAIT;
        wcnt_n  = '0;
      end else begin
        k_n = k + 2'd1;
      end
      ST_WAIT: if (wcnt == WAIT_LAST) state_n = ST_CAP;
               else                   wcnt_n  = wcnt + 8'd1;
      ST_CAP: if (i == LAST && j == LAST) begin
        state_n = ST_DONE;
      end else begin
        state_n = ST_CLR;
        if (j == LAST) begin
          j_n = '0;
          i_n = i + 2'd1;
        end else begin
          j_n = j + 2'd1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      i     <= i_n;
      j     <= j_n;
      k     <= k_n;
      wcnt  <= wcnt_n;
    end
  end

  // Outputs are decoded from the next state so they are valid during that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.mac_load  <= 1'b0;
      bus.mac_clear <= 1'b0;
      bus.mac_w     <= '0;
      bus.mac_x     <= '0;
      bus.res_valid <= 1'b0;
      bus.res_addr  <= '0;
      bus.res_data  <= '0;
    end else begin
      bus.busy      <= !(state_n inside {ST_IDLE, ST_DONE});
      bus.done      <= (state_n == ST_DONE);
      bus.mac_clear <= (state_n == ST_CLR);
      bus.mac_load  <= (state_n == ST_ACC);
      bus.mac_w     <= (state_n == ST_ACC) ? rdata[0] : '0;
      bus.mac_x     <= (state_n == ST_ACC) ? rdata[1] : '0;
      bus.res_valid <= (state_n == ST_CAP);
      if (state_n == ST_CAP) begin
        bus.res_addr <= {2'b00, i} * ROW + {2'b00, j};
        bus.res_data <= bus.mac_o;
      end
    end
  end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Randomized bench: sequencer driving a behavioural MAC, results checked against a matrix-product model.
module tb_mac_operand_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   loads = 0;
  int   ref_a[9];
  int   ref_b[9];
  int   got_addr[$];
  int   got_data[$];
  logic [9:0] acc;

  mac_operand_sequencer_if bus();

  mac_operand_sequencer #(.N(3), .MAC_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.seq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External MAC: one-cycle accumulate.
  always @(posedge clk or posedge rst) begin
    if (rst)                acc <= '0;
    else if (bus.mac_clear) acc <= '0;
    else if (bus.mac_load)  acc <= acc + {6'b0, bus.mac_w} * {6'b0, bus.mac_x};
  end
  assign bus.mac_o = acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mac_load && bus.mac_clear) chk("ld_clr_overlap", 1, 0);
      if (bus.mac_clear)     loads = 0;
      else if (bus.mac_load) loads++;
      if (bus.res_valid) begin
        chk("loads_per_elem", loads, 3);
        got_addr.push_back(int'(bus.res_addr));
        got_data.push_back(int'(bus.res_data));
      end
    end
  end

  task automatic wr(input bit sel, input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = 4'(addr);
    bus.wr_data = 4'(data);
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (addr < 9) begin
      if (sel) ref_b[addr] = data;
      else     ref_a[addr] = data;
    end
  endtask

  task automatic load(input bit sel, input int v[9]);
    for (int e = 0; e < 9; e++) wr(sel, e, v[e]);
  endtask

  task automatic run_mult(input string tag, input int inject, input bit same_wr,
                          input int sw_addr, input int sw_data);
    int  expc[9];
    int  c0;
    bit  seen;
    got_addr.delete();
    got_data.delete();
    if (same_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_sel  = 1'b0;
      bus.wr_addr = 4'(sw_addr);
      bus.wr_data = 4'(sw_data);
      if (sw_addr < 9) ref_a[sw_addr] = sw_data;
    end
    for (int e = 0; e < 9; e++) begin
      expc[e] = 0;
      for (int kk = 0; kk < 3; kk++) expc[e] += ref_a[(e / 3) * 3 + kk] * ref_b[kk * 3 + e % 3];
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    c0   = cyc;
    seen = 1'b0;
    for (int n = 1; n <= 200 && !seen; n++) begin
      if (n == inject) begin
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = 4'd0;
        bus.wr_data = 4'd7;
        chk({tag, "_busy"}, bus.busy, 1);
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    chk({tag, "_done_lat"}, seen ? cyc - c0 : 0, 54);
    chk({tag, "_busy_at_done"}, bus.busy, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, bus.done, 0);
    chk({tag, "_count"}, got_data.size(), 9);
    for (int e = 0; e < 9 && e < got_data.size(); e++) begin
      chk({tag, "_addr"}, got_addr[e], e);
      chk({tag, "_data"}, got_data[e], expc[e]);
    end
  endtask

  initial begin
    int va[9];
    int vb[9];
    int waited;
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    for (int e = 0; e < 9; e++) begin
      ref_a[e] = 0;
      ref_b[e] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_outs", {bus.busy, bus.done, bus.mac_load, bus.mac_clear, bus.res_valid,
                     bus.mac_w, bus.mac_x, bus.res_addr, bus.res_data}, 0);
    rst = 1'b0;
    @(negedge clk);

    // identity x 1..9
    for (int e = 0; e < 9; e++) begin
      va[e] = (e % 4 == 0) ? 1 : 0;
      vb[e] = e + 1;
    end
    load(1'b0, va);
    load(1'b1, vb);
    run_mult("ident", 0, 1'b0, 0, 0);

    // all 15: largest sums
    for (int e = 0; e < 9; e++) va[e] = 15;
    load(1'b0, va);
    load(1'b1, va);
    run_mult("max", 0, 1'b0, 0, 0);

    // 1..9 squared, then again with a start/write injected while busy
    for (int e = 0; e < 9; e++) va[e] = e + 1;
    load(1'b0, va);
    load(1'b1, va);
    run_mult("seq", 0, 1'b0, 0, 0);
    run_mult("busy_inject", 20, 1'b0, 0, 0);

    // random matrices
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 9; e++) begin
        va[e] = int'($urandom_range(0, 15));
        vb[e] = int'($urandom_range(0, 15));
      end
      load(1'b0, va);
      load(1'b1, vb);
      run_mult("rand", 0, 1'b0, 0, 0);
    end

    // out-of-range write dropped; same-cycle write+start uses the new value
    wr(1'b0, 12, 9);
    wr(1'b1, 15, 3);
    run_mult("oob_wr", 0, 1'b0, 0, 0);
    run_mult("same_cyc", 0, 1'b1, 4, (ref_a[4] + 5) % 16);

    // asynchronous reset during element 4
    for (int e = 0; e < 9; e++) begin
      va[e] = int'($urandom_range(1, 15));
      vb[e] = int'($urandom_range(1, 15));
    end
    load(1'b0, va);
    load(1'b1, vb);
    got_addr.delete();
    got_data.delete();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waited = 0;
    while (got_data.size() < 4 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_reach_elem4", got_data.size(), 4);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_outs", {bus.busy, bus.done, bus.mac_load, bus.mac_clear, bus.res_valid,
                         bus.mac_w, bus.mac_x, bus.res_addr, bus.res_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 9; e++) begin
      ref_a[e] = 0;
      ref_b[e] = 0;
    end
    @(negedge clk);
    run_mult("after_rst", 0, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
